// File: rtl/lock_pkg.sv
// Shared constants and types for the code entry / seven-segment display path.
package lock_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int SYM_W      = 5;
  localparam int DIG_W      = 4;

  // Display symbol codes understood by the SSD driver (0..15 are hex digits).
  localparam logic [SYM_W-1:0] SYM_BLANK = 5'd16;
  localparam logic [SYM_W-1:0] SYM_DASH  = 5'd17;
  localparam logic [SYM_W-1:0] SYM_C     = 5'd18;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_ENTRY        = 3'd1,
    ST_FULL         = 3'd2,
    ST_CHANGE_ENTRY = 3'd3,
    ST_CHANGE_FULL  = 3'd4
  } state_e;

  // A raw hex digit maps directly onto symbols 0..15.
  function automatic logic [SYM_W-1:0] digit_sym(input logic [DIG_W-1:0] d);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/code_entry_buffer_if.sv
// Button/switch inputs and display/code outputs of the code entry buffer.
interface code_entry_buffer_if;
  import lock_pkg::*;

  logic                        tick;
  logic                        clear;
  logic                        enter;
  logic                        change;
  logic [DIG_W-1:0]            switch;
  logic [NUM_DIGITS*SYM_W-1:0] ssd_word;
  logic [NUM_DIGITS*DIG_W-1:0] code;
  logic                        code_valid;
  logic                        code_is_change;
  logic                        full;

  modport master (
    output tick, clear, enter, change, switch,
    input  ssd_word, code, code_valid, code_is_change, full
  );

  modport slave (
    input  tick, clear, enter, change, switch,
    output ssd_word, code, code_valid, code_is_change, full
  );

endinterface

// File: rtl/code_entry_buffer_edge_detect.sv
// Registered rising-edge detector: one-cycle pulse per 0->1 transition.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;
  logic pulse_q;

  // Track previous level and register the rising-edge pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= level_i;
      pulse_q <= level_i & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/code_entry_buffer.sv
// Collects keypad digits into a shift buffer, masks old digits after a tick
// timeout, packs display symbols and submits complete codes to the lock ASM.
module code_entry_buffer
  import lock_pkg::*;
#(
  parameter int MASK_TICKS = 3
) (
  input logic                clk,
  input logic                rst,
  code_entry_buffer_if.slave bus
);

  localparam int TMR_W = $clog2(MASK_TICKS + 1);
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);

  logic clear_p, enter_p, change_p;

  state_e                                 state_q, state_d;
  logic [CNT_W-1:0]                       count_q, count_d;
  logic [NUM_DIGITS-1:0][DIG_W-1:0]       digits_q, digits_d;
  logic [NUM_DIGITS-1:0][TMR_W-1:0]       timers_q, timers_d, timers_dec;
  logic [NUM_DIGITS*SYM_W-1:0]            ssd_q, ssd_d;
  logic [NUM_DIGITS*DIG_W-1:0]            code_q, code_d;
  logic                                   valid_q, is_change_q, full_q;
  logic                                   submit, submit_chg, full_d;

  edge_detect u_clear  (.clk_i(clk), .rst_ni(rst), .level_i(bus.clear),  .pulse_o(clear_p));
  edge_detect u_enter  (.clk_i(clk), .rst_ni(rst), .level_i(bus.enter),  .pulse_o(enter_p));
  edge_detect u_change (.clk_i(clk), .rst_ni(rst), .level_i(bus.change), .pulse_o(change_p));

  // Per-digit mask timers count down on each tick, saturating at zero.
  always_comb begin
    timers_dec = timers_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bus.tick && (timers_q[i] != {TMR_W{1'b0}})) begin
        timers_dec[i] = timers_q[i] - TMR_W'(1);
      end else begin
        timers_dec[i] = timers_q[i];
      end
    end
  end

  // Next state, buffer and timers; clear beats enter, enter beats change.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    digits_d   = digits_q;
    timers_d   = timers_dec;
    submit     = 1'b0;
    submit_chg = 1'b0;
    if (clear_p) begin
      state_d  = ST_IDLE;
      count_d  = {CNT_W{1'b0}};
      digits_d = '0;
      timers_d = '0;
    end else if (enter_p) begin
      case (state_q)
        ST_IDLE, ST_ENTRY, ST_CHANGE_ENTRY: begin
          // Newest digit enters at position 0; a fresh digit ignores this cycle's tick.
          for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            digits_d[i] = digits_q[i-1];
            timers_d[i] = timers_dec[i-1];
          end
          digits_d[0] = bus.switch;
          timers_d[0] = TMR_W'(MASK_TICKS);
          count_d     = count_q + CNT_W'(1);
          if (count_q == CNT_W'(NUM_DIGITS - 1)) begin
            state_d = (state_q == ST_CHANGE_ENTRY) ? ST_CHANGE_FULL : ST_FULL;
          end else begin
            state_d = (state_q == ST_CHANGE_ENTRY) ? ST_CHANGE_ENTRY : ST_ENTRY;
          end
        end
        ST_FULL, ST_CHANGE_FULL: begin
          submit     = 1'b1;
          submit_chg = (state_q == ST_CHANGE_FULL);
          state_d    = ST_IDLE;
          count_d    = {CNT_W{1'b0}};
          digits_d   = '0;
          timers_d   = '0;
        end
        default: begin
          state_d  = ST_IDLE;
          count_d  = {CNT_W{1'b0}};
          digits_d = '0;
          timers_d = '0;
        end
      endcase
    end else if (change_p && (state_q == ST_IDLE)) begin
      state_d = ST_CHANGE_ENTRY;
    end else begin
      state_d = state_q;
    end
  end

  // Pack display symbols and the raw code from the next-state buffer.
  always_comb begin
    ssd_d  = {NUM_DIGITS{SYM_BLANK}};
    code_d = '0;
    full_d = (state_d == ST_FULL) || (state_d == ST_CHANGE_FULL);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (CNT_W'(i) < count_d) begin
        if (timers_d[i] == {TMR_W{1'b0}}) begin
          ssd_d[i*SYM_W +: SYM_W] = SYM_DASH;
        end else begin
          ssd_d[i*SYM_W +: SYM_W] = digit_sym(digits_d[i]);
        end
      end else if ((state_d == ST_CHANGE_ENTRY) && (count_d == {CNT_W{1'b0}}) &&
                   (i == NUM_DIGITS - 1)) begin
        ssd_d[i*SYM_W +: SYM_W] = SYM_C;
      end else begin
        ssd_d[i*SYM_W +: SYM_W] = SYM_BLANK;
      end
      // On submission the buffer empties, so present the digits being handed over.
      if (submit) begin
        code_d[i*DIG_W +: DIG_W] = digits_q[i];
      end else begin
        code_d[i*DIG_W +: DIG_W] = digits_d[i];
      end
    end
  end

  // State, buffer, timers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= {CNT_W{1'b0}};
      digits_q    <= '0;
      timers_q    <= '0;
      ssd_q       <= {NUM_DIGITS{SYM_BLANK}};
      code_q      <= '0;
      valid_q     <= 1'b0;
      is_change_q <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      digits_q    <= digits_d;
      timers_q    <= timers_d;
      ssd_q       <= ssd_d;
      code_q      <= code_d;
      valid_q     <= submit;
      is_change_q <= submit_chg;
      full_q      <= full_d;
    end
  end

  assign bus.ssd_word       = ssd_q;
  assign bus.code           = code_q;
  assign bus.code_valid     = valid_q;
  assign bus.code_is_change = is_change_q;
  assign bus.full           = full_q;

endmodule

// File: tb/tb_code_entry_buffer.sv
// Directed testbench for code_entry_buffer with hand-computed symbol words.
module tb_code_entry_buffer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  code_entry_buffer_if bus ();

  code_entry_buffer #(.MASK_TICKS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive enter for one clock; returns at the negedge after the buffer updates.
  task automatic press_enter(input logic [3:0] val);
    bus.switch = val;
    bus.enter  = 1'b1;
    @(negedge clk);
    bus.enter  = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_change();
    bus.change = 1'b1;
    @(negedge clk);
    bus.change = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_clear();
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (bus.ssd_word !== 20'h84210) begin errors++; $display("FAIL reset_ssd: got %h want %h", bus.ssd_word, 20'h84210); end
    checks++; if (bus.code !== 16'h0000) begin errors++; $display("FAIL reset_code: got %h want 0000", bus.code); end
    checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.code_valid); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // Mid-entry reset discards the held digit immediately.
    press_enter(4'h7);
    checks++; if (bus.ssd_word !== 20'h84207) begin errors++; $display("FAIL pre_reset_ssd: got %h want %h", bus.ssd_word, 20'h84207); end
    #2 rst = 1'b0;
    #1;
    checks++; if (bus.ssd_word !== 20'h84210) begin errors++; $display("FAIL midrun_reset_ssd: got %h want %h", bus.ssd_word, 20'h84210); end
    checks++; if (bus.code_is_change !== 1'b0) begin errors++; $display("FAIL midrun_reset_chg: got %b want 0", bus.code_is_change); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_entry_and_submit();
    logic [19:0] exp_ssd [4];
    exp_ssd[0] = 20'h84201;
    exp_ssd[1] = 20'h84022;
    exp_ssd[2] = 20'h80443;
    exp_ssd[3] = 20'h08864;
    for (int k = 0; k < 4; k++) begin
      press_enter(4'(k + 1));
      checks++; if (bus.ssd_word !== exp_ssd[k]) begin errors++; $display("FAIL entry_ssd_%0d: got %h want %h", k, bus.ssd_word, exp_ssd[k]); end
      checks++; if (bus.full !== (k == 3)) begin errors++; $display("FAIL entry_full_%0d: got %b want %b", k, bus.full, (k == 3)); end
    end
    // Fifth press does not add a digit; it submits the held code.
    press_enter(4'h5);
    checks++; if (bus.code_valid !== 1'b1) begin errors++; $display("FAIL submit_valid: got %b want 1", bus.code_valid); end
    checks++; if (bus.code !== 16'h1234) begin errors++; $display("FAIL submit_code: got %h want 1234", bus.code); end
    checks++; if (bus.code_is_change !== 1'b0) begin errors++; $display("FAIL submit_chg: got %b want 0", bus.code_is_change); end
    checks++; if (bus.ssd_word !== 20'h84210) begin errors++; $display("FAIL submit_ssd: got %h want %h", bus.ssd_word, 20'h84210); end
    @(negedge clk);
    checks++; if (bus.code_valid !== 1'b0) begin errors++; $display("FAIL submit_pulse_width: got %b want 0", bus.code_valid); end
    checks++; if (bus.ssd_word !== 20'h84210) begin errors++; $display("FAIL post_submit_ssd: got %h want %h", bus.ssd_word, 20'h84210); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL post_submit_full: got %b want 0", bus.full); end
  endtask

  task automatic test_masking();
    press_enter(4'hA);
    do_tick();
    do_tick();
    checks++; if (bus.ssd_word !== 20'h8420A) begin errors++; $display("FAIL mask_two_ticks: got %h want %h", bus.ssd_word, 20'h8420A); end
    do_tick();
    checks++; if (bus.ssd_word !== 20'h84211) begin errors++; $display("FAIL mask_three_ticks: got %h want %h", bus.ssd_word, 20'h84211); end
    press_enter(4'hB);
    checks++; if (bus.ssd_word !== 20'h8422B) begin errors++; $display("FAIL mask_shift: got %h want %h", bus.ssd_word, 20'h8422B); end
    press_clear();
    checks++; if (bus.ssd_word !== 20'h84210) begin errors++; $display("FAIL mask_clear: got %h want %h", bus.ssd_word, 20'h84210); end
  endtask

  task automatic test_tick_with_entry();
    press_enter(4'h5);
    // Enter pulse and tick reach the buffer on the same clock edge.
    bus.switch = 4'h6;
    bus.enter  = 1'b1;
    @(negedge clk);
    bus.enter  = 1'b0;
    bus.tick   = 1'b1;
    @(negedge clk);
    bus.tick   = 1'b0;
    checks++; if (bus.ssd_word !== 20'h840A6) begin errors++; $display("FAIL tick_entry_ssd: got %h want %h", bus.ssd_word, 20'h840A6); end
    do_tick();
    do_tick();
    checks++; if (bus.ssd_word !== 20'h84226) begin errors++; $display("FAIL tick_entry_old_masked: got %h want %h", bus.ssd_word, 20'h84226); end
    do_tick();
    checks++; if (bus.ssd_word !== 20'h84231) begin errors++; $display("FAIL tick_entry_new_masked: got %h want %h", bus.ssd_word, 20'h84231); end
    checks++; if (bus.code !== 16'h0056) begin errors++; $display("FAIL tick_entry_raw_code: got %h want 0056", bus.code); end
    press_clear();
  endtask

  task automatic test_change_mode();
    press_change();
    checks++; if (bus.ssd_word !== 20'h94210) begin errors++; $display("FAIL change_marker: got %h want %h", bus.ssd_word, 20'h94210); end
    press_enter(4'h9);
    checks++; if (bus.ssd_word !== 20'h84209) begin errors++; $display("FAIL change_first_digit: got %h want %h", bus.ssd_word, 20'h84209); end
    press_enter(4'h8);
    press_enter(4'h7);
    press_enter(4'h6);
    checks++; if (bus.ssd_word !== 20'h4A0E6) begin errors++; $display("FAIL change_full_ssd: got %h want %h", bus.ssd_word, 20'h4A0E6); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL change_full: got %b want 1", bus.full); end
    press_enter(4'h0);
    checks++; if (bus.code_valid !== 1'b1) begin errors++; $display("FAIL change_valid: got %b want 1", bus.code_valid); end
    checks++; if (bus.code !== 16'h9876) begin errors++; $display("FAIL change_code: got %h want 9876", bus.code); end
    checks++; if (bus.code_is_change !== 1'b1) begin errors++; $display("FAIL change_is_change: got %b want 1", bus.code_is_change); end
    @(negedge clk);
    checks++; if (bus.code_is_change !== 1'b0) begin errors++; $display("FAIL change_flag_width: got %b want 0", bus.code_is_change); end
  endtask

  task automatic test_priority();
    int valid_seen;
    press_enter(4'h3);
    // Clear and enter together: clear wins, nothing submitted.
    valid_seen = 0;
    bus.switch = 4'h4;
    bus.clear  = 1'b1;
    bus.enter  = 1'b1;
    @(negedge clk);
    bus.clear  = 1'b0;
    bus.enter  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.code_valid === 1'b1) valid_seen++;
      @(negedge clk);
    end
    checks++; if (bus.ssd_word !== 20'h84210) begin errors++; $display("FAIL prio_clear_ssd: got %h want %h", bus.ssd_word, 20'h84210); end
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL prio_clear_valid: got %0d pulses want 0", valid_seen); end
    // Enter and change together from idle: enter wins, no C marker.
    bus.switch = 4'h2;
    bus.enter  = 1'b1;
    bus.change = 1'b1;
    @(negedge clk);
    bus.enter  = 1'b0;
    bus.change = 1'b0;
    @(negedge clk);
    checks++; if (bus.ssd_word !== 20'h84202) begin errors++; $display("FAIL prio_enter_over_change: got %h want %h", bus.ssd_word, 20'h84202); end
    press_clear();
    // Level held high for 10 cycles enters one digit only.
    bus.switch = 4'h7;
    bus.enter  = 1'b1;
    repeat (10) @(negedge clk);
    bus.enter  = 1'b0;
    @(negedge clk);
    checks++; if (bus.ssd_word !== 20'h84207) begin errors++; $display("FAIL held_enter_ssd: got %h want %h", bus.ssd_word, 20'h84207); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL held_enter_full: got %b want 0", bus.full); end
    press_clear();
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b0;
    bus.tick   = 1'b0;
    bus.clear  = 1'b0;
    bus.enter  = 1'b0;
    bus.change = 1'b0;
    bus.switch = 4'h0;
    @(negedge clk);
    test_reset();
    test_entry_and_submit();
    test_masking();
    test_tick_with_entry();
    test_change_mode();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
